// File: rtl/demorgan_sweep_checker.sv
// Exhaustive sweep tester for De Morgan gate blocks: drives every input vector,
// waits SETTLE cycles, samples the gate output and keeps a mismatch summary.
module demorgan_sweep_checker #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      mode,
  output logic [N_IN-1:0] vec_out,
  input  logic            dut_resp,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail_vec,
  output logic [1:0]      state_dbg
);

  // Handshake: start is a request taken only in IDLE (busy low); while busy is
  // high further requests are dropped; done pulses once when pass, err_count,
  // fail_valid and first_fail_vec hold the finished sweep's result.

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);
  // With no settle time a freshly applied vector is checked on the next edge.
  localparam logic [1:0] S_APPLY = (SETTLE == 0) ? S_CHECK : S_WAIT;

  logic [1:0]    state;
  logic [1:0]    mode_q;
  logic [3:0]    settle_cnt;
  logic          expected;
  logic          mismatch;
  logic          last_vec;
  logic [N_IN:0] err_next;

  always_comb begin
    expected = 1'b0;
    case (mode_q)
      2'd0:    expected = ~(|vec_out);
      2'd1:    expected = ~(&vec_out);
      2'd2:    expected = |vec_out;
      default: expected = &vec_out;
    endcase
  end

  assign mismatch  = (dut_resp != expected);
  assign last_vec  = &vec_out;
  assign err_next  = err_count + {{N_IN{1'b0}}, mismatch};
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      mode_q         <= 2'd0;
      settle_cnt     <= 4'd0;
      vec_out        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q         <= mode;
            vec_out        <= '0;
            err_count      <= '0;
            pass           <= 1'b0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
            busy           <= 1'b1;
            settle_cnt     <= SETTLE_LD;
            state          <= S_APPLY;
          end
        end
        S_WAIT: begin
          settle_cnt <= settle_cnt - 4'd1;
          if (settle_cnt == 4'd1) state <= S_CHECK;
        end
        S_CHECK: begin
          err_count <= err_next;
          if (mismatch && !fail_valid) begin
            first_fail_vec <= vec_out;
            fail_valid     <= 1'b1;
          end
          if (last_vec) begin
            // vec_out stays all ones until the next start.
            state <= S_DONE;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            vec_out    <= vec_out + 1'b1;
            settle_cnt <= SETTLE_LD;
            state      <= S_APPLY;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
